// File: rtl/if_fetch_queue.sv
// Instruction-fetch queue: issues in-order imem requests for the PC register's
// fetch address, tracks outstanding responses, and buffers returned
// {pc, inst} pairs for decode. Stale responses are discarded after a flush.
module if_fetch_queue #(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        ce_i,
  input  logic        flush_i,
  output logic        fetch_stall_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  input  logic        id_ready_i
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(MAX_OUT + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int MW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int SW = CW + 1;

  logic [CW-1:0] count;
  logic [IW-1:0] inflight;
  logic [IW-1:0] drop_cnt;
  logic [IW-1:0] inflight_nxt;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [MW-1:0] pend_rd;
  logic [MW-1:0] pend_wr;

  logic [31:0] q_pc   [DEPTH];
  logic [31:0] q_inst [DEPTH];
  logic [31:0] pend_pc[MAX_OUT];

  logic can_issue;
  logic grant;
  logic drop;
  logic enq;
  logic deq;

  // Pending-PC pointers wrap at MAX_OUT, which need not be a power of two.
  function automatic logic [MW-1:0] pend_inc(input logic [MW-1:0] p);
    if (p == MW'(MAX_OUT - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // Issue/credit decisions; rst gates the request and stall so reset silences them at once.
  always_comb begin
    can_issue     = rst & ce_i & ~flush_i & (inflight < IW'(MAX_OUT))
                    & ((SW'(inflight) + SW'(count)) < SW'(DEPTH));
    imem_req_o    = can_issue;
    imem_addr_o   = pc_i;
    grant         = can_issue & imem_gnt_i;
    fetch_stall_o = rst & ce_i & ~flush_i & ~grant;
    drop          = (drop_cnt != '0);
    enq           = imem_rvalid_i & ~drop & ~flush_i;
    id_valid_o    = (count != '0);
    deq           = id_valid_o & id_ready_i & ~flush_i;
    inflight_nxt  = inflight + IW'(grant) - IW'(imem_rvalid_i);
    id_pc_o       = id_valid_o ? q_pc[rd_ptr] : '0;
    id_inst_o     = id_valid_o ? q_inst[rd_ptr] : '0;
  end

  // Control state: queue occupancy, pointers, outstanding and to-be-dropped responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      inflight <= '0;
      drop_cnt <= '0;
      pend_rd  <= '0;
      pend_wr  <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (grant) begin
        pend_wr <= pend_inc(pend_wr);
      end
      if (imem_rvalid_i) begin
        pend_rd <= pend_inc(pend_rd);
      end
      if (flush_i) begin
        // Everything still outstanding after this cycle belongs to the old path.
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        drop_cnt <= inflight_nxt;
      end else begin
        if (imem_rvalid_i && drop) begin
          drop_cnt <= drop_cnt - 1'b1;
        end
        if (enq) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (deq) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        count <= count + CW'(enq) - CW'(deq);
      end
    end
  end

  // Data storage needs no reset: it is only observed behind valid occupancy.
  always_ff @(posedge clk) begin
    if (grant) begin
      pend_pc[pend_wr] <= pc_i;
    end
    if (enq) begin
      q_pc[wr_ptr]   <= pend_pc[pend_rd];
      q_inst[wr_ptr] <= imem_rdata_i;
    end
  end

  // Credit accounting must make a full-queue enqueue impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(enq && (count == CW'(DEPTH))));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: models the PC register and an in-order instruction
// memory, and checks delivered {pc, inst} pairs against a scoreboard filled at grant.
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        ce_i;
  logic        flush_i;
  logic        fetch_stall_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_ready_i;

  int n_checks  = 0;
  int n_fail    = 0;
  int delivered = 0;

  bit gnt_en;
  bit resp_en;
  bit ready_en;

  logic [31:0] mem_q[$];
  logic [63:0] sb[$];

  logic        s_req;
  logic        s_stall;
  logic        s_vld;
  logic [31:0] s_addr;
  logic [31:0] s_pc;
  logic [31:0] s_inst;

  if_fetch_queue #(.DEPTH(4), .MAX_OUT(2)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .ce_i(ce_i), .flush_i(flush_i),
    .fetch_stall_o(fetch_stall_o), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .id_valid_o(id_valid_o), .id_pc_o(id_pc_o), .id_inst_o(id_inst_o), .id_ready_i(id_ready_i)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle(input logic fl, input logic [31:0] tgt);
    logic        rsp;
    logic [63:0] exp;
    flush_i       = fl;
    imem_gnt_i    = gnt_en;
    id_ready_i    = ready_en;
    rsp           = resp_en && (mem_q.size() > 0);
    imem_rvalid_i = rsp;
    imem_rdata_i  = rsp ? inst_of(mem_q[0]) : 32'hBAD0_0000;
    #1;
    s_req   = imem_req_o;
    s_stall = fetch_stall_o;
    s_addr  = imem_addr_o;
    s_vld   = id_valid_o;
    s_pc    = id_pc_o;
    s_inst  = id_inst_o;
    if (s_req) begin
      n_checks++;
      if (s_addr !== pc_i) begin
        n_fail++;
        $display("FAIL imem_addr: got %h, required %h", s_addr, pc_i);
      end
    end
    if (s_vld && ready_en && !fl) begin
      n_checks++;
      delivered++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got pc=%h inst=%h, required no delivery", s_pc, s_inst);
      end else begin
        exp = sb.pop_front();
        if ({s_pc, s_inst} !== exp) begin
          n_fail++;
          $display("FAIL sb_data: got pc=%h inst=%h, required pc=%h inst=%h",
                   s_pc, s_inst, exp[63:32], exp[31:0]);
        end
      end
    end
    @(posedge clk);
    #1;
    if (s_req && gnt_en) begin
      mem_q.push_back(pc_i);
      sb.push_back({pc_i, inst_of(pc_i)});
    end
    if (rsp) void'(mem_q.pop_front());
    if (fl) begin
      sb.delete();
      pc_i = tgt;
    end else if (ce_i && !s_stall) begin
      pc_i = pc_i + 32'd4;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst           = 1'b0;
    ce_i          = 1'b0;
    flush_i       = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    id_ready_i    = 1'b0;
    gnt_en        = 1'b0;
    resp_en       = 1'b0;
    ready_en      = 1'b0;
    mem_q.delete();
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst        = 1'b0;
    ce_i       = 1'b1;
    pc_i       = 32'h1234;
    imem_gnt_i = 1'b1;
    #1;
    n_checks++;
    if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b, required 0", imem_req_o); end
    n_checks++;
    if (fetch_stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b, required 0", fetch_stall_o); end
    n_checks++;
    if (id_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", id_valid_o); end
    n_checks++;
    if (id_pc_o !== 32'h0 || id_inst_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_head: got pc=%h inst=%h, required 0/0", id_pc_o, id_inst_o);
    end
    @(negedge clk);
    do_reset();
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset();
    pc_i = 32'h0; ce_i = 1'b1; gnt_en = 1'b1; resp_en = 1'b1; ready_en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cycle(1'b0, 32'h0);
      n_checks++;
      if (s_stall !== 1'b0) begin n_fail++; $display("FAIL stream_stall k=%0d: got %b, required 0", k, s_stall); end
      n_checks++;
      if (k < 3) begin
        if (s_vld !== 1'b0) begin n_fail++; $display("FAIL stream_early k=%0d: got valid %b, required 0", k, s_vld); end
      end else begin
        exp_pc = 32'((k - 3) * 4);
        if (s_vld !== 1'b1 || s_pc !== exp_pc) begin
          n_fail++;
          $display("FAIL stream_head k=%0d: got valid=%b pc=%h, required 1/%h", k, s_vld, s_pc, exp_pc);
        end
      end
    end
  endtask

  task automatic test_fill();
    do_reset();
    pc_i = 32'h0; ce_i = 1'b1; gnt_en = 1'b1; resp_en = 1'b1; ready_en = 1'b0;
    repeat (8) cycle(1'b0, 32'h0);
    n_checks++;
    if (s_req !== 1'b0 || s_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_backpressure: got req=%b stall=%b, required 0/1", s_req, s_stall);
    end
    n_checks++;
    if (sb.size() != 4) begin n_fail++; $display("FAIL fill_count: got %0d granted, required 4", sb.size()); end
    n_checks++;
    if (s_vld !== 1'b1 || s_pc !== 32'h0 || s_inst !== inst_of(32'h0)) begin
      n_fail++;
      $display("FAIL fill_head: got valid=%b pc=%h inst=%h, required 1/0/%h", s_vld, s_pc, s_inst, inst_of(32'h0));
    end
    ready_en = 1'b1;
    repeat (10) cycle(1'b0, 32'h0);
  endtask

  task automatic test_gnt_stall();
    logic found;
    do_reset();
    pc_i = 32'h10; ce_i = 1'b1; gnt_en = 1'b0; resp_en = 1'b1; ready_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 32'h0);
      n_checks++;
      if (s_stall !== 1'b1 || s_req !== 1'b1 || s_addr !== 32'h10) begin
        n_fail++;
        $display("FAIL gnt_wait: got stall=%b req=%b addr=%h, required 1/1/00000010", s_stall, s_req, s_addr);
      end
    end
    gnt_en = 1'b1;
    found  = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 32'h0);
      if (s_vld) begin found = 1'b1; break; end
    end
    n_checks++;
    if (!found || s_pc !== 32'h10) begin
      n_fail++;
      $display("FAIL gnt_first: got found=%b pc=%h, required 1/00000010", found, s_pc);
    end
  endtask

  task automatic test_flush();
    logic found;
    do_reset();
    pc_i = 32'h20; ce_i = 1'b1; gnt_en = 1'b1; resp_en = 1'b0; ready_en = 1'b1;
    repeat (2) cycle(1'b0, 32'h0);
    cycle(1'b0, 32'h0);
    n_checks++;
    if (s_req !== 1'b0 || s_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_limit: got req=%b stall=%b, required 0/1", s_req, s_stall);
    end
    resp_en = 1'b1;
    cycle(1'b1, 32'h100);
    n_checks++;
    if (s_req !== 1'b0 || s_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_cycle: got req=%b stall=%b, required 0/0", s_req, s_stall);
    end
    cycle(1'b0, 32'h0);
    n_checks++;
    if (s_vld !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got valid %b, required 0", s_vld); end
    found = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cycle(1'b0, 32'h0);
      if (s_vld) begin found = 1'b1; break; end
    end
    n_checks++;
    if (!found || s_pc !== 32'h100) begin
      n_fail++;
      $display("FAIL flush_target: got found=%b pc=%h, required 1/00000100", found, s_pc);
    end
  endtask

  task automatic test_back_to_back();
    int          start;
    logic [31:0] tgt;
    do_reset();
    pc_i = 32'h40; ce_i = 1'b1; gnt_en = 1'b1; resp_en = 1'b1; ready_en = 1'b0;
    repeat (4) cycle(1'b0, 32'h0);
    start    = delivered;
    ready_en = 1'b1;
    repeat (16) cycle(1'b0, 32'h0);
    n_checks++;
    if (delivered - start < 10) begin
      n_fail++;
      $display("FAIL b2b_throughput: got %0d delivered, required at least 10", delivered - start);
    end
    for (int k = 0; k < 300; k++) begin
      gnt_en   = ($urandom_range(0, 3) != 0);
      resp_en  = ($urandom_range(0, 3) != 0);
      ready_en = ($urandom_range(0, 2) != 0);
      ce_i     = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 19) == 0) begin
        tgt = 32'h1000 + ($urandom_range(0, 255) << 2);
        cycle(1'b1, tgt);
      end else begin
        cycle(1'b0, 32'h0);
      end
    end
    ce_i = 1'b0; resp_en = 1'b1; ready_en = 1'b1;
    repeat (10) cycle(1'b0, 32'h0);
    n_checks++;
    if (sb.size() != 0 || s_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: got %0d undelivered valid=%b, required 0/0", sb.size(), s_vld);
    end
  endtask

  task automatic test_reset_mid();
    logic found;
    do_reset();
    pc_i = 32'h80; ce_i = 1'b1; gnt_en = 1'b1; resp_en = 1'b1; ready_en = 1'b1;
    repeat (6) cycle(1'b0, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (id_valid_o !== 1'b0 || id_pc_o !== 32'h0 || id_inst_o !== 32'h0) begin
      n_fail++;
      $display("FAIL async_head: got valid=%b pc=%h inst=%h, required 0", id_valid_o, id_pc_o, id_inst_o);
    end
    n_checks++;
    if (imem_req_o !== 1'b0 || fetch_stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL async_req: got req=%b stall=%b, required 0/0", imem_req_o, fetch_stall_o);
    end
    mem_q.delete();
    sb.delete();
    imem_rvalid_i = 1'b0;
    pc_i = 32'h200;
    repeat (2) @(negedge clk);
    rst   = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 32'h0);
      if (s_vld) begin found = 1'b1; break; end
    end
    n_checks++;
    if (!found || s_pc !== 32'h200) begin
      n_fail++;
      $display("FAIL reset_resume: got found=%b pc=%h, required 1/00000200", found, s_pc);
    end
    repeat (6) cycle(1'b0, 32'h0);
  endtask

  initial begin
    rst           = 1'b0;
    pc_i          = '0;
    ce_i          = 1'b0;
    flush_i       = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    id_ready_i    = 1'b0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_fill();
    test_gnt_stall();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Consumes the PC register's pc/ce outputs and issues in-order requests to instruction memory over a grant/rvalid handshake.
- Buffers returned {pc, inst} pairs in a small FIFO that feeds the IF/ID boundary.
- Back-pressures the PC register via a stall request and discards stale fetches on branch flush.

Parameters:
- DEPTH, 4, entries in the instruction queue; power of 2, ≥2.
- MAX_OUT, 2, maximum imem requests granted but not yet returned; 1..DEPTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous active-low reset (0 = reset).
- pc_i  input  32  current fetch PC from the PC register.
- ce_i  input  1  chip enable from the PC register; 0 = no fetching.
- flush_i  input  1  branch taken this cycle; same cycle the PC register loads the target.
- fetch_stall_o  output  1  stall request to the PC register (drives stall[0]); 1 = hold pc.
- imem_req_o  output  1  fetch request valid.
- imem_addr_o  output  32  fetch address; equals pc_i.
- imem_gnt_i  input  1  memory accepts the request this cycle.
- imem_rvalid_i  input  1  read data valid; responses in order, ≥1 cycle after grant.
- imem_rdata_i  input  32  instruction word.
- id_valid_o  output  1  queue head valid to decode.
- id_pc_o  output  32  PC of head instruction.
- id_inst_o  output  32  head instruction word.
- id_ready_i  input  1  decode consumes the head this cycle.

Behaviour:
- Reset (rst=0, asynchronous):
  - Queue empty; inflight=0; drop_cnt=0.
  - id_valid_o=0, id_pc_o=0, id_inst_o=0.
  - imem_req_o=0, fetch_stall_o=0.
  - Pending PC FIFO cleared.
  - Reset mid-transaction abandons all inflight responses; the bench must not drive rvalid for them after release.
- Issue condition: can_issue = ce_i & ~flush_i & (inflight < MAX_OUT) & (inflight + count < DEPTH).
  - imem_req_o = can_issue.
  - imem_addr_o = pc_i.
- Grant: imem_req_o & imem_gnt_i pushes pc_i into an internal pending-PC FIFO (depth MAX_OUT) and increments inflight.
- fetch_stall_o = ce_i & ~flush_i & ~(imem_req_o & imem_gnt_i).
  - The PC register advances exactly once per granted request.
  - fetch_stall_o is forced 0 in the flush cycle so the branch target is loaded.
  - fetch_stall_o is 0 while ce_i=0.
- Response (imem_rvalid_i):
  - Pops the pending-PC FIFO and decrements inflight.
  - If drop_cnt>0: discard the response and decrement drop_cnt.
  - Otherwise: enqueue {popped pc, imem_rdata_i}.
  - Latency rvalid→id_valid_o is 1 cycle; no bypass.
- Credit accounting guarantees the queue never overflows. An enqueue with count=DEPTH is an assertion failure.
- Dequeue: id_valid_o & id_ready_i pops the head. The head stays stable while id_ready_i=0.
  - Enqueue and dequeue in the same cycle: count unchanged.
- Counter widths: count holds 0..DEPTH; inflight and drop_cnt hold 0..MAX_OUT. Read/write pointers wrap modulo DEPTH.
- flush_i=1:
  - Next cycle: queue empty, id_valid_o=0.
  - drop_cnt ← inflight after this cycle's response decrement.
  - No request issued in the flush cycle.
  - A response arriving in the flush cycle is dropped.
  - flush_i has priority over a same-cycle dequeue and enqueue.
- ce_i=0: no requests issued. Queue contents and inflight responses are handled normally.

Test Plan:
- Reset then ce_i=1, pc_i=0x0, imem grant every cycle, rdata 1 cycle later → id_valid_o first at cycle 3 with id_pc_o=0x0; id_pc_o=0x4, 0x8 on following cycles; fetch_stall_o=0 throughout.
- id_ready_i held 0 with immediate grants → exactly DEPTH(4) entries fill (pc 0x0..0xC); then imem_req_o=0 and fetch_stall_o=1; head held at 0x0 until id_ready_i=1.
- imem_gnt_i=0 for 3 cycles at pc=0x10 → fetch_stall_o=1 and imem_addr_o=0x10 constant; on grant, next response carries pc 0x10.
- Two requests inflight (0x20, 0x24) when flush_i=1 and the target is 0x100 → both responses discarded, id_valid_o=0; first delivered entry has id_pc_o=0x100.
- Enqueue and dequeue in the same cycle with count=3 → count remains 3; order preserved across pointer wrap (≥10 instructions through DEPTH=4).
- rst pulsed low mid-stream → all outputs 0 immediately (asynchronous); after release, fetch resumes cleanly from the new pc_i.
